// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad event unit: PS1-style layout bit
// positions, register offsets and the MiSTer-to-layout remap function.
package gamepad_pkg;

    typedef logic [15:0] pad_bits_t;

    localparam int BTN_UP       = 0;
    localparam int BTN_DOWN     = 1;
    localparam int BTN_LEFT     = 2;
    localparam int BTN_RIGHT    = 3;
    localparam int BTN_TRIANGLE = 4;
    localparam int BTN_CIRCLE   = 5;
    localparam int BTN_CROSS    = 6;
    localparam int BTN_SQUARE   = 7;
    localparam int BTN_SELECT   = 8;
    localparam int BTN_START    = 9;
    localparam int BTN_L1       = 10;
    localparam int BTN_R1       = 11;
    localparam int BTN_L2       = 12;
    localparam int BTN_R2       = 13;

    localparam logic [1:0] REG_STATE    = 2'd0;
    localparam logic [1:0] REG_PRESSED  = 2'd1;
    localparam logic [1:0] REG_RELEASED = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam int CTRL_EN_BIT = 31;

    // Only the low 14 MiSTer bits carry buttons; layout bits 15:14 stay 0.
    function automatic pad_bits_t remap_joy(input logic [13:0] j);
        pad_bits_t r;
        r               = '0;
        r[BTN_UP]       = j[3];
        r[BTN_DOWN]     = j[2];
        r[BTN_LEFT]     = j[1];
        r[BTN_RIGHT]    = j[0];
        r[BTN_TRIANGLE] = j[9];
        r[BTN_CIRCLE]   = j[7];
        r[BTN_CROSS]    = j[6];
        r[BTN_SQUARE]   = j[8];
        r[BTN_SELECT]   = j[5];
        r[BTN_START]    = j[4];
        r[BTN_L1]       = j[10];
        r[BTN_R1]       = j[11];
        r[BTN_L2]       = j[12];
        r[BTN_R2]       = j[13];
        return r;
    endfunction

endpackage

// File: rtl/gamepad_event_unit_if.sv
// CPU-side register bus of the gamepad event unit. The address decoder
// drives addr_match and the word index; the unit answers one cycle later.
interface gamepad_event_unit_if #(
    parameter int IDX_W = 5
) ();
    logic             addr_match;
    logic             read_stb;
    logic             write_stb;
    logic [IDX_W-1:0] reg_idx;
    logic [31:0]      wr_data;
    logic [31:0]      data_out;
    logic             rd_valid;

    modport master (
        output addr_match, read_stb, write_stb, reg_idx, wr_data,
        input  data_out, rd_valid
    );

    modport slave (
        input  addr_match, read_stb, write_stb, reg_idx, wr_data,
        output data_out, rd_valid
    );
endinterface

// File: rtl/gamepad_debounce.sv
// Sixteen-bit debouncer for one pad. A bit only changes after the input has
// disagreed with it for DEB_CYCLES consecutive cycles. rise/fall flag the
// cycle whose clock edge will flip the stable value, so edge latches in the
// parent update on the same edge as the stable bit.
module gamepad_debounce
    import gamepad_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  pad_bits_t raw,
    output pad_bits_t stable,
    output pad_bits_t rise,
    output pad_bits_t fall
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt [16];
    pad_bits_t        flip;

    // A bit flips when it still disagrees and its counter has run out.
    always_comb begin
        flip = '0;
        for (int b = 0; b < 16; b++) begin
            flip[b] = (raw[b] != stable[b]) && (cnt[b] == CNT_LAST);
        end
    end

    assign rise = flip & raw;
    assign fall = flip & ~raw;

    // Per-bit disagreement counters and the stable value they guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int b = 0; b < 16; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 16; b++) begin
                if (raw[b] == stable[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    stable[b] <= raw[b];
                    cnt[b]    <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gamepad_event_unit.sv
// Gamepad event unit: remaps NUM_PADS MiSTer joystick words, debounces every
// button, latches press/release edges into write-1-to-clear registers and
// raises a maskable level interrupt. Word index = 4*pad + register.
module gamepad_event_unit
    import gamepad_pkg::*;
#(
    parameter int NUM_PADS   = 4,
    parameter int DEB_CYCLES = 4,
    parameter int IDX_W      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [32*NUM_PADS-1:0]  joy_in,
    gamepad_event_unit_if.slave     bus,
    output logic                    irq
);

    localparam int PAD_W = IDX_W - 2;

    logic [1:0]       reg_sel;
    logic [PAD_W-1:0] pad_sel;
    logic             pad_hit    [NUM_PADS];
    pad_bits_t        stable_a   [NUM_PADS];
    pad_bits_t        pressed_a  [NUM_PADS];
    pad_bits_t        released_a [NUM_PADS];
    pad_bits_t        mask_a     [NUM_PADS];
    logic             en_a       [NUM_PADS];
    logic [31:0]      rd_word;
    logic             irq_next;
    logic             rd_req;
    logic [14:0]      wr_data_unused;

    assign reg_sel        = bus.reg_idx[1:0];
    assign pad_sel        = bus.reg_idx[IDX_W-1:2];
    assign rd_req         = bus.addr_match & bus.read_stb;
    assign wr_data_unused = bus.wr_data[30:16];

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        pad_bits_t   raw_q;
        pad_bits_t   stable;
        pad_bits_t   rise;
        pad_bits_t   fall;
        pad_bits_t   pressed;
        pad_bits_t   released;
        pad_bits_t   irq_mask;
        pad_bits_t   clr_pressed;
        pad_bits_t   clr_released;
        logic        pad_en;
        logic        wr_hit;
        logic [17:0] joy_hi_unused;

        assign joy_hi_unused = joy_in[32*p+14 +: 18];
        assign pad_hit[p]    = (pad_sel == PAD_W'(p));
        assign wr_hit        = bus.addr_match & bus.write_stb & pad_hit[p];
        assign clr_pressed   = (wr_hit && reg_sel == REG_PRESSED)  ? bus.wr_data[15:0] : '0;
        assign clr_released  = (wr_hit && reg_sel == REG_RELEASED) ? bus.wr_data[15:0] : '0;

        // Sample the remapped pad; a disabled pad is seen as fully released.
        always_ff @(posedge clk) begin
            if (reset) begin
                raw_q <= '0;
            end else begin
                raw_q <= pad_en ? remap_joy(joy_in[32*p +: 14]) : '0;
            end
        end

        gamepad_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_q),
            .stable (stable),
            .rise   (rise),
            .fall   (fall)
        );

        // Sticky edge latches (a new edge beats a same-cycle clear) and CTRL.
        always_ff @(posedge clk) begin
            if (reset) begin
                pressed  <= '0;
                released <= '0;
                irq_mask <= '0;
                pad_en   <= 1'b1;
            end else begin
                pressed  <= (pressed & ~clr_pressed) | (rise & {16{pad_en}});
                released <= (released & ~clr_released) | fall;
                if (wr_hit && reg_sel == REG_CTRL) begin
                    irq_mask <= bus.wr_data[15:0];
                    pad_en   <= bus.wr_data[CTRL_EN_BIT];
                end
            end
        end

        assign stable_a[p]   = stable;
        assign pressed_a[p]  = pressed;
        assign released_a[p] = released;
        assign mask_a[p]     = irq_mask;
        assign en_a[p]       = pad_en;
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (pad_hit[p]) begin
                case (reg_sel)
                    REG_STATE:    rd_word = {16'h0, stable_a[p]};
                    REG_PRESSED:  rd_word = {16'h0, pressed_a[p]};
                    REG_RELEASED: rd_word = {16'h0, released_a[p]};
                    default:      rd_word = {en_a[p], 15'h0, mask_a[p]};
                endcase
            end
        end
    end

    // Interrupt condition: any pad with an unmasked pending press.
    always_comb begin
        irq_next = 1'b0;
        for (int p = 0; p < NUM_PADS; p++) begin
            irq_next = irq_next | (|(pressed_a[p] & mask_a[p]));
        end
    end

    // Registered read response and interrupt output.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_out <= '0;
            bus.rd_valid <= 1'b0;
            irq          <= 1'b0;
        end else begin
            bus.data_out <= rd_req ? rd_word : '0;
            bus.rd_valid <= rd_req;
            irq          <= irq_next;
        end
    end

endmodule

// File: tb/tb_gamepad_event_unit.sv
// Directed testbench for gamepad_event_unit with hand-computed expectations
// (NUM_PADS=4, DEB_CYCLES=4, IDX_W=5).
module tb_gamepad_event_unit;

    localparam int NUM_PADS   = 4;
    localparam int DEB_CYCLES = 4;
    localparam int IDX_W      = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [32*NUM_PADS-1:0] joy_in;
    logic                   irq;
    logic [31:0]            rd_d;
    logic                   rd_v;
    int                     vectors     = 0;
    int                     miscompares = 0;

    gamepad_event_unit_if #(.IDX_W(IDX_W)) bus ();

    gamepad_event_unit #(
        .NUM_PADS   (NUM_PADS),
        .DEB_CYCLES (DEB_CYCLES),
        .IDX_W      (IDX_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .joy_in (joy_in),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle read strobe; returns the response presented the next cycle.
    task automatic bus_read(input int idx, output logic [31:0] d, output logic v);
        bus.addr_match = 1'b1;
        bus.read_stb   = 1'b1;
        bus.reg_idx    = IDX_W'(idx);
        tick(1);
        d = bus.data_out;
        v = bus.rd_valid;
        bus.addr_match = 1'b0;
        bus.read_stb   = 1'b0;
    endtask

    // One-cycle write strobe.
    task automatic bus_write(input int idx, input logic [31:0] d);
        bus.addr_match = 1'b1;
        bus.write_stb  = 1'b1;
        bus.reg_idx    = IDX_W'(idx);
        bus.wr_data    = d;
        tick(1);
        bus.addr_match = 1'b0;
        bus.write_stb  = 1'b0;
        bus.wr_data    = '0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        joy_in         = '0;
        bus.addr_match = 1'b0;
        bus.read_stb   = 1'b0;
        bus.write_stb  = 1'b0;
        bus.reg_idx    = '0;
        bus.wr_data    = '0;
        tick(3);
        vectors++;
        if (irq !== 1'b0 || bus.rd_valid !== 1'b0 || bus.data_out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: irq=%b rd_valid=%b data=%h, want 0/0/0", irq, bus.rd_valid, bus.data_out);
        end
        reset = 1'b0;
        tick(1);
        bus_read(3, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h8000_0000 || rd_v !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: data=%h valid=%b, want 80000000/1", rd_d, rd_v);
        end
        tick(1);
        vectors++;
        if (bus.rd_valid !== 1'b0 || bus.data_out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL idle_bus: data=%h valid=%b, want 0/0", bus.data_out, bus.rd_valid);
        end
        bus_read(0, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0 || rd_v !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_state: data=%h valid=%b, want 0/1", rd_d, rd_v);
        end
    endtask

    task automatic test_debounce();
        joy_in[3] = 1'b1;
        tick(4);
        bus_read(0, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL up_too_early: data=%h, want 0", rd_d);
        end
        bus_read(0, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL up_state: data=%h, want 1", rd_d);
        end
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL up_pressed: data=%h, want 1", rd_d);
        end
        // Glitch one cycle shorter than the debounce window.
        joy_in[9] = 1'b1;
        tick(3);
        joy_in[9] = 1'b0;
        tick(8);
        bus_read(0, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL glitch_state: data=%h, want 1", rd_d);
        end
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL glitch_pressed: data=%h, want 1", rd_d);
        end
        // Pulse exactly as long as the window gets through.
        joy_in[9] = 1'b1;
        tick(4);
        joy_in[9] = 1'b0;
        tick(10);
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h11) begin
            miscompares++;
            $display("[TB] FAIL pulse_pressed: data=%h, want 11", rd_d);
        end
        bus_read(2, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h10) begin
            miscompares++;
            $display("[TB] FAIL pulse_released: data=%h, want 10", rd_d);
        end
        joy_in[3] = 1'b0;
        tick(8);
        bus_read(2, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h11) begin
            miscompares++;
            $display("[TB] FAIL up_released: data=%h, want 11", rd_d);
        end
        bus_write(1, 32'hFFFF_FFFF);
        bus_write(2, 32'hFFFF_FFFF);
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL clear_all: data=%h, want 0", rd_d);
        end
    endtask

    task automatic test_pad2_w1c();
        joy_in[64+7] = 1'b1;
        tick(8);
        joy_in[64+7] = 1'b0;
        tick(8);
        bus_read(9, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h20) begin
            miscompares++;
            $display("[TB] FAIL pad2_pressed: data=%h, want 20", rd_d);
        end
        bus_read(10, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h20) begin
            miscompares++;
            $display("[TB] FAIL pad2_released: data=%h, want 20", rd_d);
        end
        bus_write(9, 32'h20);
        bus_read(9, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL pad2_w1c: data=%h, want 0", rd_d);
        end
        bus_write(10, 32'h0);
        bus_read(10, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h20) begin
            miscompares++;
            $display("[TB] FAIL pad2_write0: data=%h, want 20", rd_d);
        end
        bus_write(10, 32'h20);
    endtask

    task automatic test_set_wins();
        joy_in[3] = 1'b1;
        tick(4);
        bus_write(1, 32'h1);
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL set_beats_clear: data=%h, want 1", rd_d);
        end
        // Read and write together: read returns the value before the clear.
        bus.addr_match = 1'b1;
        bus.read_stb   = 1'b1;
        bus.write_stb  = 1'b1;
        bus.reg_idx    = IDX_W'(1);
        bus.wr_data    = 32'h1;
        tick(1);
        rd_d = bus.data_out;
        rd_v = bus.rd_valid;
        bus.addr_match = 1'b0;
        bus.read_stb   = 1'b0;
        bus.write_stb  = 1'b0;
        bus.wr_data    = '0;
        vectors++;
        if (rd_d !== 32'h1 || rd_v !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rw_prewrite: data=%h valid=%b, want 1/1", rd_d, rd_v);
        end
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL rw_cleared: data=%h, want 0", rd_d);
        end
        joy_in[3] = 1'b0;
        tick(8);
        bus_write(2, 32'hFFFF);
    endtask

    task automatic test_irq();
        bus_write(7, 32'h8000_0200);
        bus_read(7, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h8000_0200) begin
            miscompares++;
            $display("[TB] FAIL ctrl_rw: data=%h, want 80000200", rd_d);
        end
        joy_in[32+4] = 1'b1;
        tick(5);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_early: irq=%b, want 0", irq);
        end
        tick(1);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_assert: irq=%b, want 1", irq);
        end
        bus_write(5, 32'h200);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_hold: irq=%b, want 1", irq);
        end
        tick(1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_clear: irq=%b, want 0", irq);
        end
        joy_in[3] = 1'b1;
        tick(8);
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h1 || irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_masked: pressed=%h irq=%b, want 1/0", rd_d, irq);
        end
        joy_in[3]    = 1'b0;
        joy_in[32+4] = 1'b0;
        tick(8);
        bus_write(1, 32'hFFFF);
        bus_write(2, 32'hFFFF);
        bus_write(5, 32'hFFFF);
        bus_write(6, 32'hFFFF);
        bus_write(7, 32'h8000_0000);
    endtask

    task automatic test_range_enable();
        bus_read(16, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0 || rd_v !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL range_read: data=%h valid=%b, want 0/1", rd_d, rd_v);
        end
        bus_write(19, 32'h0000_0001);
        bus_read(3, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h8000_0000) begin
            miscompares++;
            $display("[TB] FAIL range_write: pad0 ctrl=%h, want 80000000", rd_d);
        end
        joy_in[3] = 1'b1;
        tick(8);
        bus_write(1, 32'hFFFF);
        bus_write(3, 32'h0);
        tick(4);
        bus_read(2, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL disable_early: released=%h, want 0", rd_d);
        end
        bus_read(2, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL disable_release: released=%h, want 1", rd_d);
        end
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL disable_nopress: pressed=%h, want 0", rd_d);
        end
        bus_read(3, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL disable_ctrl: ctrl=%h, want 0", rd_d);
        end
        bus_write(3, 32'h8000_0000);
        tick(8);
        bus_read(1, rd_d, rd_v);
        vectors++;
        if (rd_d !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL reenable_press: pressed=%h, want 1", rd_d);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_pad2_w1c();
        test_set_wins();
        test_irq();
        test_range_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/gamepad_event_unit.md
Name: gamepad_event_unit

Overview:
- Parametrised successor to the 2-player pad register block: maps NUM_PADS MiSTer joystick words to the Cylon-X 16-bit PS1 button layout.
- Debounces each button.
- Latches press and release edges into sticky write-1-to-clear registers.
- Raises a maskable level interrupt.
- Sits on the CPU memory-mapped bus at 0x1002xxxx; the bus decoder supplies addr_match and the word index.

Parameters:
- NUM_PADS, 4, number of controllers (1..8).
- DEB_CYCLES, 4, consecutive stable cycles required before a debounced bit changes (1..255; 1 = follow input with one-cycle lag).
- IDX_W, 5, width of the bus word index (must satisfy 2^IDX_W >= 4*NUM_PADS).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- joy_in  in  32*NUM_PADS  MiSTer joystick words, pad p at [32p+31:32p], active high
- addr_match  in  1  CPU is addressing this block
- read_stb  in  1  read request, single-cycle qualified by addr_match
- write_stb  in  1  write request, single-cycle qualified by addr_match
- reg_idx  in  IDX_W  32-bit word index within the block
- wr_data  in  32  write data
- data_out  out  32  read data
- rd_valid  out  1  data_out holds a read result this cycle
- irq  out  1  level interrupt, OR over pads of (PRESSED & IRQ_MASK)

Behaviour:

Remap (combinational, per pad, MiSTer bit -> layout bit):
- 3->0 Up, 2->1 Down, 1->2 Left, 0->3 Right.
- 9->4 Triangle, 7->5 Circle, 6->6 Cross, 8->7 Square.
- 5->8 Select, 4->9 Start.
- 10->10 L1, 11->11 R1, 12->12 L2, 13->13 R2.
- Bits 15:14 are 0.

Input sampling:
- Remapped raw value is registered once (raw_q) before debounce.

Debounce, per pad per bit:
- State: stable bit S and counter C of width clog2(DEB_CYCLES+1).
- If raw_q == S: C <= 0.
- Else if C == DEB_CYCLES-1: S <= raw_q and C <= 0.
- Else: C <= C+1.
- A glitch shorter than DEB_CYCLES cycles never changes S.
- Latency from joy_in change to S change is DEB_CYCLES+1 cycles.

Edge latches, per pad:
- PRESSED[b] sets on S 0->1; RELEASED[b] sets on S 1->0.
- Both are sticky until cleared by a write of 1 to that bit.
- A write of 0 has no effect.
- Edge and W1C on the same bit in the same cycle: set wins, the bit stays 1.

Register map, word index = 4*p + r:
- r=0 STATE: read {16'h0, S}; read-only.
- r=1 PRESSED: read {16'h0, PRESSED}; W1C on bits 15:0.
- r=2 RELEASED: read {16'h0, RELEASED}; W1C on bits 15:0.
- r=3 CTRL: [15:0] IRQ_MASK, [31] pad enable; RW; other bits read 0.
- Pad index p >= NUM_PADS: reads return 0, writes are ignored.

Pad enable:
- Pad enable = 0 forces raw_q of that pad to 0, so buttons debounce to released.
- No further PRESSED bits are set while disabled.
- Existing sticky bits remain set.

Bus reads:
- On addr_match & read_stb at cycle N, data_out and rd_valid=1 are presented in cycle N+1.
- Otherwise data_out = 0 and rd_valid = 0.
- Reads have no side effects.
- read_stb and write_stb asserted together: the write executes, and the read returns the pre-write value.

irq:
- Registered.
- Asserts one cycle after any PRESSED&IRQ_MASK bit becomes nonzero.
- Deasserts one cycle after that condition clears.

Reset, all synchronous:
- S, C, raw_q, PRESSED, RELEASED, IRQ_MASK = 0.
- Pad enable = 1.
- data_out = 0, rd_valid = 0, irq = 0.
- A button held through reset deassertion produces a PRESSED edge DEB_CYCLES+1 cycles after reset falls (S starts at 0).

Decomposition:
- Shared package gamepad_pkg:
  - Layout bit-position constants BTN_UP..BTN_R2.
  - Register offset constants REG_STATE=0, REG_PRESSED=1, REG_RELEASED=2, REG_CTRL=3.
  - CTRL_EN_BIT=31.
  - typedef pad_bits_t (logic [15:0]).
- One sub-module: gamepad_debounce (one pad, 16 bits, DEB_CYCLES parameter), outputs S plus rise/fall pulses; instantiated NUM_PADS times.
- Remap is a package function.

Test Plan:
1. Reset, then read idx 3 -> data_out=32'h8000_0000 with rd_valid=1 one cycle after strobe; read idx 0 -> 0.
2. DEB_CYCLES=4: set joy_in pad0 bit3 (Up) high -> STATE reads 16'h0001 from cycle 5 after the change; PRESSED=16'h0001; a 3-cycle pulse on bit 9 produces no change.
3. Pad2 raw bit 7 (A) set then released -> PRESSED idx 9 = 0x0020 and RELEASED idx 10 = 0x0020; write 0x0020 to idx 9 -> reads 0; write 0 -> no change.
4. W1C on PRESSED bit 0 coincident with a new debounced rising edge on bit 0 -> bit remains 1.
5. Write CTRL pad1 = 0x8000_0200, press Start on pad1 -> irq=1 one cycle after PRESSED bit 9 sets; W1C bit 9 -> irq=0 next cycle; a press on pad0 (mask 0) leaves irq=0.
6. NUM_PADS=4: read idx 16 -> 0; write idx 19 -> ignored. Clear pad0 enable while Up held -> RELEASED bit 0 sets after DEB_CYCLES+1 cycles.
